// File: rtl/gate_bist_ctrl.sv
// In-place self-test sequencer for a 2-input combinational gate: walks {a,b} through
// 00,01,10,11, samples y after SETTLE_CYCLES clocks per vector, and reports pass/fail.
module gate_bist_ctrl #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] EXPECTED      = 4'b1110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
);

  localparam int                CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ab_q, ab_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [3:0]       mask_q, mask_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      ab_q    <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      ab_q    <= ab_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    ab_d    = ab_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        // abort outranks start, so asserting both never launches a run
        if (start && !abort) begin
          state_d = RUN;
          vec_d   = '0;
          cnt_d   = '0;
          ab_d    = 2'b00;
          pass_d  = 1'b0;
          mask_d  = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          vec_d   = '0;
          cnt_d   = '0;
          ab_d    = 2'b00;
          pass_d  = 1'b0;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          if (gate_y != EXPECTED[vec_q]) mask_d[vec_q] = 1'b1;
          cnt_d = '0;
          if (vec_q != 2'd3) begin
            vec_d = vec_q + 2'd1;
            ab_d  = vec_q + 2'd1;
          end else begin
            // verdict includes the vector-3 sample taken on this same edge
            state_d = IDLE;
            vec_d   = '0;
            ab_d    = 2'b00;
            done_d  = 1'b1;
            pass_d  = (mask_d == 4'b0000);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gate_a    = ab_q[1];
    gate_b    = ab_q[0];
    busy      = (state_q == RUN);
    done      = done_q;
    pass      = pass_q;
    fail_mask = mask_q;
  end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl: an OR-checking instance (S=2) and a NOR-checking
// instance (S=1) driven from vector tables and a few hand-written multi-cycle sequences.
module tb_gate_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // instance 0: OR, S=2
  logic       start0, abort0, a0, b0, y0, busy0, done0, pass0;
  logic [3:0] mask0;
  logic [1:0] ymode;  // 0 ideal OR, 1 stuck-at-0, 2 stuck-at-1

  // instance 1: NOR, S=1
  logic       start1, abort1, a1, b1, y1, busy1, done1, pass1;
  logic [3:0] mask1;

  always_comb begin
    case (ymode)
      2'd1:    y0 = 1'b0;
      2'd2:    y0 = 1'b1;
      default: y0 = a0 | b0;
    endcase
  end
  assign y1 = ~(a1 | b1);

  gate_bist_ctrl #(.SETTLE_CYCLES(2), .EXPECTED(4'b1110)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .gate_a(a0), .gate_b(b0), .gate_y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_mask(mask0));

  gate_bist_ctrl #(.SETTLE_CYCLES(1), .EXPECTED(4'b0001)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .gate_a(a1), .gate_b(b1), .gate_y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_mask(mask1));

  int n_cmp = 0;
  int n_bad = 0;

  // outputs packed as {busy,done,pass,a,b,mask[3:0]}
  function automatic logic [8:0] outs0();
    return {busy0, done0, pass0, a0, b0, mask0};
  endfunction
  function automatic logic [8:0] outs1();
    return {busy1, done1, pass1, a1, b1, mask1};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       start;
    logic       abort;
    logic [1:0] ymode;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[19];
  int   done_k, done_k2, seen;
  logic pass_at_done, pass_at_done2;

  initial begin
    // ideal OR, one full run (edges E0..E0+9)
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 9'b1_0_0_00_0000};
    tbl[1]  = '{1'b0, 1'b0, 2'd0, 9'b1_0_0_00_0000};
    tbl[2]  = '{1'b0, 1'b0, 2'd0, 9'b1_0_0_01_0000};
    tbl[3]  = '{1'b0, 1'b0, 2'd0, 9'b1_0_0_01_0000};
    tbl[4]  = '{1'b0, 1'b0, 2'd0, 9'b1_0_0_10_0000};
    tbl[5]  = '{1'b0, 1'b0, 2'd0, 9'b1_0_0_10_0000};
    tbl[6]  = '{1'b0, 1'b0, 2'd0, 9'b1_0_0_11_0000};
    tbl[7]  = '{1'b0, 1'b0, 2'd0, 9'b1_0_0_11_0000};
    tbl[8]  = '{1'b0, 1'b0, 2'd0, 9'b0_1_1_00_0000};
    tbl[9]  = '{1'b0, 1'b0, 2'd0, 9'b0_0_1_00_0000};
    // stuck-at-0 against OR: vectors 1,2,3 mismatch as they are sampled
    tbl[10] = '{1'b1, 1'b0, 2'd1, 9'b1_0_0_00_0000};
    tbl[11] = '{1'b0, 1'b0, 2'd1, 9'b1_0_0_00_0000};
    tbl[12] = '{1'b0, 1'b0, 2'd1, 9'b1_0_0_01_0000};
    tbl[13] = '{1'b0, 1'b0, 2'd1, 9'b1_0_0_01_0000};
    tbl[14] = '{1'b0, 1'b0, 2'd1, 9'b1_0_0_10_0010};
    tbl[15] = '{1'b0, 1'b0, 2'd1, 9'b1_0_0_10_0010};
    tbl[16] = '{1'b0, 1'b0, 2'd1, 9'b1_0_0_11_0110};
    tbl[17] = '{1'b0, 1'b0, 2'd1, 9'b1_0_0_11_0110};
    tbl[18] = '{1'b0, 1'b0, 2'd1, 9'b0_1_0_00_1110};

    start0 = 0; abort0 = 0; start1 = 0; abort1 = 0; ymode = 2'd0;

    // reset state
    rst_n = 1'b0;
    #12;
    check("reset_u0", 32'(outs0()), 32'h0);
    check("reset_u1", 32'(outs1()), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_after_reset", 32'(outs0()), 32'h0);

    // table-driven runs
    for (int i = 0; i < 19; i++) begin
      start0 = tbl[i].start;
      abort0 = tbl[i].abort;
      ymode  = tbl[i].ymode;
      step();
      check($sformatf("tbl[%0d]", i), 32'(outs0()), 32'(tbl[i].exp));
    end
    start0 = 0;
    step();

    // start re-pulsed mid-run is ignored; done stays at E0+8
    ymode = 2'd0; done_k = -1; pass_at_done = 1'b0;
    for (int k = 0; k < 13; k++) begin
      start0 = (k == 0 || k == 3);
      step();
      if (done0 && done_k < 0) begin done_k = k; pass_at_done = pass0; end
    end
    start0 = 0;
    check("restart_ignored_done_edge", 32'(done_k), 32'd8);
    check("restart_ignored_pass", 32'(pass_at_done), 32'd1);

    // stuck-at-1 aborted at E0+6: vector 0 already failed, no done
    ymode = 2'd2; seen = 0;
    for (int k = 0; k < 6; k++) begin
      start0 = (k == 0);
      step();
      if (done0) seen++;
    end
    abort0 = 1'b1;
    step();
    check("abort_state", 32'(outs0()), 32'(9'b0_0_0_00_0001));
    abort0 = 1'b0;
    step();
    if (done0) seen++;
    check("abort_no_done", 32'(seen), 32'd0);
    // start and abort together in IDLE: nothing starts, mask kept
    start0 = 1'b1; abort0 = 1'b1;
    step();
    check("start_abort_idle", 32'(outs0()), 32'(9'b0_0_0_00_0001));
    start0 = 1'b0; abort0 = 1'b0;
    step();

    // start held high: second run accepted on the done cycle
    ymode = 2'd0; done_k = -1; done_k2 = -1; pass_at_done = 0; pass_at_done2 = 0;
    start0 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done0) begin
        if (done_k < 0) begin done_k = k; pass_at_done = pass0; end
        else if (done_k2 < 0) begin done_k2 = k; pass_at_done2 = pass0; end
      end
      if (k == 9) check("b2b_busy_restart", 32'(busy0), 32'd1);
    end
    start0 = 1'b0;
    check("b2b_done1_edge", 32'(done_k), 32'd8);
    check("b2b_done2_edge", 32'(done_k2), 32'd17);
    check("b2b_pass", 32'({pass_at_done, pass_at_done2}), 32'd3);
    step(); step();

    // S=1 NOR instance: done at E0+4
    done_k = -1; pass_at_done = 0;
    for (int k = 0; k < 7; k++) begin
      start1 = (k == 0);
      step();
      if (k == 2) check("nor_vec2_drive", 32'({a1, b1}), 32'd2);
      if (done1 && done_k < 0) begin done_k = k; pass_at_done = pass1; end
    end
    check("nor_done_edge", 32'(done_k), 32'd4);
    check("nor_pass", 32'(pass_at_done), 32'd1);

    // reset mid-run at E0+2 of a new run
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step(); step();
    check("nor_busy_before_rst", 32'(busy1), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("midrun_reset", 32'(outs1()), 32'h0);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (done1) seen++;
    end
    check("reset_no_done", 32'(seen), 32'd0);
    check("reset_idle", 32'(outs1()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
